fpalu_round_pack: RTL and testbench

//  Downstream stage of the FP ALU multiplier datapath. Takes the raw multiply

---
 rtl/fpalu_round_pack_if.sv | 25 ++
 rtl/fpalu_round_pack.sv | 163 ++++++++++++++++
 tb/tb_fpalu_round_pack.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpalu_round_pack_if.sv
// Handshake and data bundle for fpalu_round_pack: raw multiply result in,
// packed single-precision word plus exception flags out.
interface fpalu_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [8:0]  in_exp;
  logic [47:0] in_product;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;
  logic        inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_product, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_product, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );
endinterface

// File: rtl/fpalu_round_pack.sv
// Multiplier back end: normalize, round-to-nearest-even, renormalize and pack
// into IEEE-754 single in a 3-stage pipeline that stalls as one unit.
module fpalu_round_pack #(
  parameter int BIAS  = 127,
  parameter int EXP_W = 10
) (
  input logic               clock,
  input logic               reset,
  fpalu_round_pack_if.slave bus
);
  localparam logic signed [EXP_W-1:0] ADJ_HI = EXP_W'(BIAS - 1);
  localparam logic signed [EXP_W-1:0] ADJ_LO = EXP_W'(BIAS);
  localparam logic signed [EXP_W-1:0] E_MAX  = EXP_W'(255);
  localparam logic signed [EXP_W-1:0] E_MIN  = EXP_W'(0);
  localparam logic signed [EXP_W-1:0] E_ONE  = EXP_W'(1);

  logic        en;
  logic        out_valid_q;
  logic [31:0] result_q;
  logic        overflow_q, underflow_q, inexact_q;

  assign en           = !out_valid_q || bus.out_ready;
  assign bus.in_ready = en;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
  assign bus.inexact   = inexact_q;

  logic signed [EXP_W-1:0] exp_in, s1_e_d;
  logic [47:0]             s1_m_d;
  logic                    s1_zero_d, s1_flush_d;

  assign exp_in = $signed({{(EXP_W-9){1'b0}}, bus.in_exp});

  always_comb begin
    s1_zero_d  = 1'b0;
    s1_flush_d = 1'b0;
    s1_m_d     = bus.in_product;
    s1_e_d     = exp_in - ADJ_HI;
    if (bus.in_product == '0) begin
      s1_zero_d = 1'b1;
    end else if (!bus.in_product[47]) begin
      if (bus.in_product[46]) begin
        s1_m_d = {bus.in_product[46:0], 1'b0};
        s1_e_d = exp_in - ADJ_LO;
      end else begin
        s1_flush_d = 1'b1;
      end
    end
  end

  logic                    s1_v, s1_sign, s1_zero, s1_flush;
  logic signed [EXP_W-1:0] s1_e;
  logic [47:0]             s1_m;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_v     <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_flush <= 1'b0;
      s1_e     <= '0;
      s1_m     <= '0;
    end else if (en) begin
      s1_v     <= bus.in_valid;
      s1_sign  <= bus.in_sign;
      s1_zero  <= s1_zero_d;
      s1_flush <= s1_flush_d;
      s1_e     <= s1_e_d;
      s1_m     <= s1_m_d;
    end
  end

  // RNE on the 24-bit significand; the 25th bit catches the all-ones carry.
  logic [23:0] kept;
  logic        guard, sticky, round_up;
  logic [24:0] s2_k_d;

  assign kept     = s1_m[47:24];
  assign guard    = s1_m[23];
  assign sticky   = |s1_m[22:0];
  assign round_up = guard & (sticky | kept[0]);
  assign s2_k_d   = {1'b0, kept} + {24'b0, round_up};

  logic                    s2_v, s2_sign, s2_zero, s2_flush, s2_ix;
  logic signed [EXP_W-1:0] s2_e;
  logic [24:0]             s2_k;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s2_v     <= 1'b0;
      s2_sign  <= 1'b0;
      s2_zero  <= 1'b0;
      s2_flush <= 1'b0;
      s2_ix    <= 1'b0;
      s2_e     <= '0;
      s2_k     <= '0;
    end else if (en) begin
      s2_v     <= s1_v;
      s2_sign  <= s1_sign;
      s2_zero  <= s1_zero;
      s2_flush <= s1_flush;
      s2_ix    <= guard | sticky;
      s2_e     <= s1_e;
      s2_k     <= s2_k_d;
    end
  end

  logic signed [EXP_W-1:0] e_fin;
  logic [22:0]             frac;
  logic [31:0]             res_d;
  logic                    ovf_d, unf_d, inx_d;

  // A flushed product carries no meaningful exponent, so it is resolved
  // before the exponent range checks.
  always_comb begin
    e_fin = s2_e;
    frac  = s2_k[22:0];
    if (s2_k[24]) begin
      e_fin = s2_e + E_ONE;
      frac  = s2_k[23:1];
    end
    res_d = {s2_sign, e_fin[7:0], frac};
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = s2_ix;
    if (s2_zero) begin
      res_d = {s2_sign, 31'b0};
      inx_d = 1'b0;
    end else if (s2_flush) begin
      res_d = {s2_sign, 31'b0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_fin >= E_MAX) begin
      res_d = {s2_sign, 8'hFF, 23'b0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_fin <= E_MIN) begin
      res_d = {s2_sign, 31'b0};
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else if (en) begin
      out_valid_q <= s2_v;
      if (s2_v) begin
        result_q    <= res_d;
        overflow_q  <= ovf_d;
        underflow_q <= unf_d;
        inexact_q   <= inx_d;
      end
    end
  end
endmodule

// File: tb/tb_fpalu_round_pack.sv
// Self-checking bench for fpalu_round_pack: directed vectors, backpressure,
// full-rate streaming, random traffic and mid-stream reset against a value model.
module tb_fpalu_round_pack;
  typedef struct {
    logic        sign;
    logic [8:0]  exp;
    logic [47:0] prod;
  } op_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  fpalu_round_pack_if bus();

  fpalu_round_pack dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Value-level model: scale the product so its leading one sits at 2^47,
  // split into a 24-bit integer part and a 24-bit remainder, round to even.
  function automatic logic [34:0] model(input op_t op);
    longint unsigned mant, keep, rem;
    int              e;
    logic            ix;
    logic [31:0]     r;
    if (op.prod == 48'd0) return {op.sign, 31'b0, 3'b000};
    if (op.prod >= 48'h800000000000) begin
      mant = 64'(op.prod);
      e    = int'(op.exp) - 127 + 1;
    end else if (op.prod >= 48'h400000000000) begin
      mant = 64'(op.prod) * 2;
      e    = int'(op.exp) - 127;
    end else begin
      return {op.sign, 31'b0, 3'b011};
    end
    keep = mant / 64'd16777216;
    rem  = mant % 64'd16777216;
    ix   = (rem != 0);
    if (rem > 64'd8388608 || (rem == 64'd8388608 && (keep % 2) == 1)) keep = keep + 1;
    if (keep == 64'd16777216) begin
      keep = keep / 2;
      e    = e + 1;
    end
    if (e >= 255) return {op.sign, 8'hFF, 23'b0, 3'b101};
    if (e <= 0)   return {op.sign, 31'b0, 3'b011};
    r = {op.sign, 8'(e), 23'(keep)};
    return {r, 2'b00, ix};
  endfunction

  function automatic op_t rand_op(input bit normal_only);
    op_t         op;
    logic [47:0] ma, mb;
    int          kind;
    op.sign = 1'($urandom_range(1));
    kind    = normal_only ? 9 : int'($urandom_range(19));
    ma      = {24'b0, 1'b1, 23'($urandom)};
    mb      = {24'b0, 1'b1, 23'($urandom)};
    op.prod = ma * mb;
    if (kind == 0) op.prod = 48'd0;
    else if (kind == 1) op.prod = {2'b00, 46'({$urandom, $urandom})} | 48'd1;
    else if (kind == 2) op.prod[23:0] = ($urandom_range(1) == 1) ? 24'h800000 : 24'h400000;
    if (normal_only) op.exp = 9'($urandom_range(350, 160));
    else if ($urandom_range(3) == 0) op.exp = 9'($urandom_range(510));
    else op.exp = 9'($urandom_range(390, 120));
    return op;
  endfunction

  task automatic test_reset();
    bus.in_valid   = 1'b0;
    bus.in_sign    = 1'b0;
    bus.in_exp     = 9'd0;
    bus.in_product = 48'd0;
    bus.out_ready  = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if (bus.result !== 32'h0) begin
      n_fail++; $display("FAIL reset_result: got %h expected 00000000", bus.result);
    end
    n_checks++;
    if ({bus.overflow, bus.underflow, bus.inexact} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.overflow, bus.underflow, bus.inexact});
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
    reset = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    op_t         v[18];
    logic [34:0] want[18];
    logic [34:0] got;
    int          lat;
    v[0]  = '{1'b0, 9'd254, 48'h900000000000}; want[0]  = {32'h40100000, 3'b000};
    v[1]  = '{1'b0, 9'd254, 48'h400000000000}; want[1]  = {32'h3F800000, 3'b000};
    v[2]  = '{1'b1, 9'd254, 48'h400000000000}; want[2]  = {32'hBF800000, 3'b000};
    v[3]  = '{1'b0, 9'd254, 48'h400000400000}; want[3]  = {32'h3F800000, 3'b001};
    v[4]  = '{1'b0, 9'd254, 48'h400000C00000}; want[4]  = {32'h3F800002, 3'b001};
    v[5]  = '{1'b0, 9'd254, 48'h7FFFFFC00000}; want[5]  = {32'h40000000, 3'b001};
    v[6]  = '{1'b0, 9'd400, 48'h400000000000}; want[6]  = {32'h7F800000, 3'b101};
    v[7]  = '{1'b1, 9'd100, 48'h400000000000}; want[7]  = {32'h80000000, 3'b011};
    v[8]  = '{1'b0, 9'd254, 48'h000000000000}; want[8]  = {32'h00000000, 3'b000};
    v[9]  = '{1'b1, 9'd254, 48'h000000000000}; want[9]  = {32'h80000000, 3'b000};
    v[10] = '{1'b0, 9'd381, 48'h400000000000}; want[10] = {32'h7F000000, 3'b000};
    v[11] = '{1'b0, 9'd382, 48'h400000000000}; want[11] = {32'h7F800000, 3'b101};
    v[12] = '{1'b0, 9'd128, 48'h400000000000}; want[12] = {32'h00800000, 3'b000};
    v[13] = '{1'b0, 9'd127, 48'h400000000000}; want[13] = {32'h00000000, 3'b011};
    v[14] = '{1'b1, 9'd254, 48'h000000001234}; want[14] = {32'h80000000, 3'b011};
    v[15] = '{1'b0, 9'd381, 48'h7FFFFFC00000}; want[15] = {32'h7F800000, 3'b101};
    v[16] = '{1'b0, 9'd254, 48'h400000200000}; want[16] = {32'h3F800000, 3'b001};
    v[17] = '{1'b0, 9'd254, 48'h900000800000}; want[17] = {32'h40100000, 3'b001};
    for (int i = 0; i < 18; i++) begin
      bus.out_ready  = 1'b1;
      bus.in_valid   = 1'b1;
      bus.in_sign    = v[i].sign;
      bus.in_exp     = v[i].exp;
      bus.in_product = v[i].prod;
      @(posedge clock); #1;
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 10) begin
        @(posedge clock); #1;
        lat++;
      end
      got = {bus.result, bus.overflow, bus.underflow, bus.inexact};
      n_checks++;
      if (lat != 3) begin
        n_fail++; $display("FAIL directed_latency[%0d]: got %0d cycles expected 3", i, lat);
      end
      n_checks++;
      if (got !== want[i]) begin
        n_fail++; $display("FAIL directed_value[%0d]: got %h/ovf-unf-inx %b expected %h/%b",
                           i, got[34:3], got[2:0], want[i][34:3], want[i][2:0]);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_backpressure();
    op_t         ops[5];
    logic [34:0] expq[$];
    logic [34:0] e;
    logic [31:0] held;
    int          sent = 0, got = 0, cyc = 0;
    held = 32'h0;
    for (int i = 0; i < 5; i++) ops[i] = rand_op(1'b1);
    while (got < 5 && cyc < 60) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 7);
      bus.in_valid  = (sent < 5);
      if (sent < 5) begin
        bus.in_sign    = ops[sent].sign;
        bus.in_exp     = ops[sent].exp;
        bus.in_product = ops[sent].prod;
      end
      @(negedge clock);
      if (cyc >= 4 && cyc <= 7) begin
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready cyc %0d: got %b expected 0", cyc, bus.in_ready);
        end
        if (cyc == 4) held = bus.result;
        else begin
          n_checks++;
          if (bus.result !== held) begin
            n_fail++; $display("FAIL bp_result_stable cyc %0d: got %h expected %h", cyc, bus.result, held);
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(ops[sent]));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL bp_extra_output: got %h expected no output", bus.result);
        end else begin
          e = expq.pop_front();
          if ({bus.result, bus.overflow, bus.underflow, bus.inexact} !== e) begin
            n_fail++; $display("FAIL bp_value #%0d: got %h/%b expected %h/%b", got, bus.result,
                               {bus.overflow, bus.underflow, bus.inexact}, e[34:3], e[2:0]);
          end
        end
        got++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    n_checks++;
    if (got != 5 || sent != 5 || expq.size() != 0) begin
      n_fail++; $display("FAIL bp_count: got out=%0d in=%0d pending=%0d expected 5 5 0", got, sent, expq.size());
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_stream(input int n, input int rdy_pct, input int vld_pct,
                             input bit exact_rate, input string tag);
    op_t         ops[$];
    logic [34:0] expq[$];
    logic [34:0] e;
    int          sent = 0, got = 0, cyc = 0;
    for (int i = 0; i < n; i++) ops.push_back(rand_op(1'b0));
    while (got < n && cyc < n * 30 + 50) begin
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      if (sent < n && $urandom_range(99) < vld_pct) begin
        bus.in_valid   = 1'b1;
        bus.in_sign    = ops[sent].sign;
        bus.in_exp     = ops[sent].exp;
        bus.in_product = ops[sent].prod;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clock);
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back(model(ops[sent]));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_checks++;
        if (expq.size() == 0) begin
          n_fail++; $display("FAIL %s_extra_output: got %h expected no output", tag, bus.result);
        end else begin
          e = expq.pop_front();
          if ({bus.result, bus.overflow, bus.underflow, bus.inexact} !== e) begin
            n_fail++; $display("FAIL %s_value #%0d: got %h/%b expected %h/%b", tag, got, bus.result,
                               {bus.overflow, bus.underflow, bus.inexact}, e[34:3], e[2:0]);
          end
        end
        got++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    n_checks++;
    if (got != n || sent != n || expq.size() != 0) begin
      n_fail++; $display("FAIL %s_count: got out=%0d in=%0d pending=%0d expected %0d %0d 0",
                         tag, got, sent, expq.size(), n, n);
    end
    if (exact_rate) begin
      n_checks++;
      if (cyc != n + 3) begin
        n_fail++; $display("FAIL %s_rate: got %0d cycles expected %0d", tag, cyc, n + 3);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  task automatic test_reset_mid();
    op_t op;
    int  seen = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      op = rand_op(1'b1);
      bus.in_valid   = 1'b1;
      bus.in_sign    = op.sign;
      bus.in_exp     = op.exp;
      bus.in_product = op.prod;
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result === 32'h0) begin
      n_fail++; $display("FAIL rst_mid_precondition: got valid=%b result=%h expected valid=1 nonzero",
                         bus.out_valid, bus.result);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid);
    end
    n_checks++;
    if ({bus.result, bus.overflow, bus.underflow, bus.inexact} !== 35'h0) begin
      n_fail++; $display("FAIL rst_mid_result: got %h/%b expected 00000000/000", bus.result,
                         {bus.overflow, bus.underflow, bus.inexact});
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (6) begin
      @(posedge clock); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rst_mid_replay: got %0d outputs expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_stream(40, 100, 100, 1'b1, "back_to_back");
    test_stream(300, 60, 70, 1'b0, "random");
    test_reset_mid();
    test_stream(20, 80, 90, 1'b0, "after_reset");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
